// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types, tap constants and the single-step LFSR function.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  // Maximal-length masks for this register's convention: the feedback bit enters
  // the MSB, the state shifts right, and bit 0 is the output. Under that
  // convention a mask m is maximal when x^W + sum(m[i] * x^i) is primitive.
  localparam logic [3:0]  TAPS_W4  = 4'h3;          // x^4+x+1
  localparam logic [4:0]  TAPS_W5  = 5'h05;         // x^5+x^2+1
  localparam logic [7:0]  TAPS_W8  = 8'h1D;         // x^8+x^4+x^3+x^2+1
  localparam logic [15:0] TAPS_W16 = 16'h6801;      // x^16+x^14+x^13+x^11+1
  localparam logic [31:0] TAPS_W32 = 32'h0040_0007; // x^32+x^22+x^2+x+1

  typedef struct packed {
    logic        bit_out;
    logic [31:0] next;
  } step_t;

  // One Fibonacci step on a register of width w (1..32), zero-extended to 32 bits.
  function automatic step_t lfsr_step(input logic [31:0] st,
                                      input logic [31:0] taps,
                                      input int unsigned w);
    step_t r;
    logic  fb;
    fb        = ^(st & taps);
    r.bit_out = st[0];
    r.next    = (st >> 1) | ({31'b0, fb} << (w - 1));
    return r;
  endfunction

endpackage

// File: rtl/lfsr_word_gen_if.sv
// lfsr_word_gen_if: valid/ready word channel from the generator to its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds out_ready low; producer keeps out_valid/out_data stable.
// Ports: out_valid, out_data[OUT_W] (producer -> consumer), out_ready (consumer -> producer).
interface lfsr_word_gen_if #(
  parameter int unsigned OUT_W = 8
);
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: W-bit Fibonacci LFSR register with seed load and all-zero recovery.
// Latency: new state visible one cycle after step/load; lockup is a registered 1-cycle pulse.
// Backpressure: steps only when step_en is high; otherwise holds.
// Ports: clk, reset_n (sync, active-low), step_en, load, load_seed[W] in;
//        state[W], bit_out (state[0]), stepped (a step happens this cycle), lockup out.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned  W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step_en,
  input  logic         load,
  input  logic [W-1:0] load_seed,
  output logic [W-1:0] state,
  output logic         bit_out,
  output logic         stepped,
  output logic         lockup
);

  step_t nxt;
  logic  unused_nxt;

  always_comb begin
    nxt = lfsr_step(32'(state), 32'(TAPS), W);
  end

  // Upper bits above W are always zero; fold them away explicitly.
  assign unused_nxt = ^nxt.next;
  assign bit_out    = nxt.bit_out;

  // A zero state is never stepped: the recovery cycle replaces it instead.
  assign stepped = step_en && !load && (state != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= SEED;
      lockup <= 1'b0;
    end else if (load) begin
      state  <= (load_seed == '0) ? SEED : load_seed;
      lockup <= (load_seed == '0);
    end else if (state == '0) begin
      state  <= SEED;
      lockup <= 1'b1;
    end else begin
      lockup <= 1'b0;
      if (step_en) begin
        state <= nxt.next[W-1:0];
      end
    end
  end

endmodule

// File: rtl/lfsr_word_gen.sv
// lfsr_word_gen: packs LFSR output bits (first bit in the MSB) into OUT_W-bit words.
// Latency: out_valid rises OUT_W+1 cycles after enable is first seen; one word per OUT_W+1 cycles.
// Backpressure: holds the word (and freezes the LFSR) until out_valid && out_ready.
// Ports: clk, reset_n (sync, active-low), enable, load, load_seed[W] in;
//        out_if (master: out_valid, out_data[OUT_W], out_ready); lockup, state[W] out.
module lfsr_word_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned  W     = 16,
  parameter logic [W-1:0] TAPS  = 16'hB400,
  parameter logic [W-1:0] SEED  = {W{1'b1}},
  parameter int unsigned  OUT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [W-1:0]          load_seed,
  lfsr_word_gen_if.master       out_if,
  output logic                  lockup,
  output logic [W-1:0]          state
);

  localparam int unsigned CW = $clog2(OUT_W + 1);

  fsm_t             fsm_q, fsm_d;
  logic [CW-1:0]    count_q;
  logic [OUT_W-1:0] acc_q, acc_nxt;
  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic             step_en, stepped, bit_out, word_done;

  assign step_en = (fsm_q == GEN) && enable;

  lfsr_core #(
    .W    (W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .step_en   (step_en),
    .load      (load),
    .load_seed (load_seed),
    .state     (state),
    .bit_out   (bit_out),
    .stepped   (stepped),
    .lockup    (lockup)
  );

  // Shift form keeps OUT_W=1 legal (no [OUT_W-2:0] slice).
  assign acc_nxt   = (acc_q << 1) | OUT_W'(bit_out);
  assign word_done = stepped && (count_q == CW'(OUT_W - 1));

  always_comb begin
    fsm_d = fsm_q;
    if (load) begin
      fsm_d = enable ? GEN : IDLE;
    end else begin
      case (fsm_q)
        IDLE:    if (enable) fsm_d = GEN;
        GEN:     if (word_done) fsm_d = HOLD;
        HOLD:    if (valid_q && out_if.out_ready) fsm_d = enable ? GEN : IDLE;
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      if (load) begin
        // Partial word and any held word are dropped.
        count_q <= '0;
        acc_q   <= '0;
        valid_q <= 1'b0;
      end else if (word_done) begin
        count_q <= '0;
        acc_q   <= '0;
        data_q  <= acc_nxt;
        valid_q <= 1'b1;
      end else if (stepped) begin
        count_q <= count_q + 1'b1;
        acc_q   <= acc_nxt;
      end else if (fsm_q == HOLD && valid_q && out_if.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// tb_lfsr_word_gen: directed scenarios plus a randomized run against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lfsr_word_gen;
  import lfsr_pkg::*;

  localparam logic [3:0] TAPS_A = 4'b0011;
  localparam logic [3:0] TAPS_B = 4'b0010;

  logic       clk = 1'b0;
  logic       rst_n, en, ld, rdy;
  logic [3:0] sd;
  logic [3:0] st_a, st_b;
  logic       lk_a, lk_b;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  lfsr_word_gen_if #(.OUT_W(4)) ifa ();
  lfsr_word_gen_if #(.OUT_W(4)) ifb ();
  assign ifa.out_ready = rdy;
  assign ifb.out_ready = rdy;

  lfsr_word_gen #(.W(4), .TAPS(TAPS_A), .SEED(4'hF), .OUT_W(4)) dut_a (
    .clk(clk), .reset_n(rst_n), .enable(en), .load(ld), .load_seed(sd),
    .out_if(ifa), .lockup(lk_a), .state(st_a));

  lfsr_word_gen #(.W(4), .TAPS(TAPS_B), .SEED(4'hF), .OUT_W(4)) dut_b (
    .clk(clk), .reset_n(rst_n), .enable(en), .load(ld), .load_seed(sd),
    .out_if(ifb), .lockup(lk_b), .state(st_b));

  // ---------------- reference model (dut_a only) ----------------
  int         m_state, m_mode;   // m_mode: 0 idle, 1 generating, 2 holding a word
  logic       m_valid, m_lock;
  logic [3:0] m_data;
  int         m_bits[$];

  task automatic model_reset();
    m_state = 15; m_mode = 0; m_valid = 0; m_lock = 0; m_data = 0;
    m_bits.delete();
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [3:0] s, input logic r);
    int fb, word;
    m_lock = 0;
    if (l) begin
      m_state = (s == 0) ? 15 : int'(s);
      m_lock  = (s == 0);
      m_bits.delete();
      m_valid = 0;
      m_mode  = e ? 1 : 0;
      return;
    end
    if (m_state == 0) begin
      m_state = 15;
      m_lock  = 1;
    end else if (m_mode == 1 && e) begin
      m_bits.push_back(m_state % 2);
      fb      = $countones(m_state & int'(TAPS_A)) % 2;
      m_state = m_state / 2 + fb * 8;
    end
    case (m_mode)
      0: if (e) m_mode = 1;
      1: if (m_bits.size() == 4) begin
           word = 0;
           foreach (m_bits[i]) word = word * 2 + m_bits[i];
           m_data  = 4'(word);
           m_valid = 1;
           m_bits.delete();
           m_mode  = 2;
         end
      default: if (r) begin
           m_valid = 0;
           m_mode  = e ? 1 : 0;
         end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; ld = 0; rdy = 0; sd = 0;
    tick();
    rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (st_a !== 4'hF) begin errors++; $display("FAIL reset_state: got %h want f", st_a); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifa.out_valid); end
    checks++; if (ifa.out_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ifa.out_data); end
    checks++; if (lk_a !== 1'b0 || lk_b !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b%b want 00", lk_a, lk_b); end
  endtask

  task automatic test_sequence();
    logic [3:0] words[$];
    logic [3:0] prev, got;
    int steps = 0, first_vld = -1;
    bit back = 0;
    logic [3:0] exp_w[3] = '{4'hF, 4'h1, 4'h3};
    do_reset();
    en = 1; rdy = 1;
    prev = st_a;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (!back && st_a !== prev) begin
        steps++;
        if (st_a === 4'hF) back = 1;
      end
      prev = st_a;
      if (ifa.out_valid === 1'b1 && first_vld < 0) first_vld = n;
      if (ifa.out_valid === 1'b1 && words.size() < 3) words.push_back(ifa.out_data);
    end
    checks++; if (first_vld != 5) begin errors++; $display("FAIL first_valid_latency: got %0d want 5", first_vld); end
    for (int i = 0; i < 3; i++) begin
      got = (i < words.size()) ? words[i] : 4'hx;
      checks++; if (got !== exp_w[i]) begin errors++; $display("FAIL seq_word%0d: got %h want %h", i, got, exp_w[i]); end
    end
    checks++; if (!back || steps != 15) begin errors++; $display("FAIL period: got %0d steps (returned=%0d) want 15", steps, back); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    en = 1; rdy = 0;
    while (ifa.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL bp_wait: valid %b after %0d cycles want 1", ifa.out_valid, n); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_data !== 4'hF || st_a !== 4'b1000) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h state=%b want 1/f/1000", i, ifa.out_valid, ifa.out_data, st_a);
      end
    end
    rdy = 1;
    tick();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer: valid %b want 0", ifa.out_valid); end
    n = 0;
    while (ifa.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 4 || ifa.out_data !== 4'h1) begin errors++; $display("FAIL bp_next_word: data %h after %0d cycles want 1 after 4", ifa.out_data, n); end
  endtask

  task automatic test_enable_pause();
    int n = 0;
    do_reset();
    en = 1; rdy = 1;
    tick(); tick(); n = 2;
    en = 0;
    for (int i = 0; i < 5; i++) begin tick(); n++; end
    checks++; if (st_a !== 4'b0111) begin errors++; $display("FAIL pause_state: got %b want 0111", st_a); end
    en = 1;
    while (ifa.out_valid !== 1'b1 && n < 30) begin tick(); n++; end
    checks++; if (n != 10) begin errors++; $display("FAIL pause_latency: got %0d want 10", n); end
    checks++; if (ifa.out_data !== 4'hF) begin errors++; $display("FAIL pause_word0: got %h want f", ifa.out_data); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 4'h1) begin errors++; $display("FAIL pause_word1: valid=%b data=%h want 1/1", ifa.out_valid, ifa.out_data); end
  endtask

  task automatic test_load();
    logic [3:0] exp_s[4] = '{4'b0100, 4'b0010, 4'b1001, 4'b1100};
    do_reset();
    en = 1; rdy = 1;
    tick(); tick(); tick();
    checks++; if (st_a !== 4'b0011) begin errors++; $display("FAIL load_pre: got %b want 0011", st_a); end
    ld = 1; sd = 4'b1000;
    tick();
    ld = 0;
    checks++; if (st_a !== 4'b1000 || ifa.out_valid !== 1'b0) begin errors++; $display("FAIL load_state: got %b valid=%b want 1000/0", st_a, ifa.out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (st_a !== exp_s[i]) begin errors++; $display("FAIL load_seq%0d: got %b want %b", i, st_a, exp_s[i]); end
    end
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 4'h1) begin errors++; $display("FAIL load_word: valid=%b data=%h want 1/1", ifa.out_valid, ifa.out_data); end
  endtask

  task automatic test_lockup();
    do_reset();
    en = 1; ld = 1; sd = 4'b0001;
    tick();
    ld = 0;
    checks++; if (st_b !== 4'b0001 || lk_b !== 1'b0) begin errors++; $display("FAIL lk_load: state=%b lockup=%b want 0001/0", st_b, lk_b); end
    tick();
    checks++; if (st_b !== 4'b0000 || lk_b !== 1'b0) begin errors++; $display("FAIL lk_zero: state=%b lockup=%b want 0000/0", st_b, lk_b); end
    tick();
    checks++; if (st_b !== 4'b1111 || lk_b !== 1'b1) begin errors++; $display("FAIL lk_recover: state=%b lockup=%b want 1111/1", st_b, lk_b); end
    tick();
    checks++; if (lk_b !== 1'b0) begin errors++; $display("FAIL lk_pulse_width: lockup=%b want 0", lk_b); end
    ld = 1; sd = 4'b0000;
    tick();
    ld = 0;
    checks++; if (st_b !== 4'b1111 || lk_b !== 1'b1) begin errors++; $display("FAIL lk_zero_load: state=%b lockup=%b want 1111/1", st_b, lk_b); end
    tick();
    checks++; if (lk_b !== 1'b0) begin errors++; $display("FAIL lk_zero_load_end: lockup=%b want 0", lk_b); end
  endtask

  task automatic test_reset_in_hold();
    int n = 0;
    do_reset();
    en = 1; rdy = 0;
    while (ifa.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL rh_wait: valid %b want 1", ifa.out_valid); end
    rst_n = 0;
    tick();
    checks++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 4'h0 || st_a !== 4'hF || lk_a !== 1'b0) begin
      errors++;
      $display("FAIL rh_reset: valid=%b data=%h state=%h lockup=%b want 0/0/f/0", ifa.out_valid, ifa.out_data, st_a, lk_a);
    end
    rst_n = 1; rdy = 1; n = 0;
    while (ifa.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (n != 5 || ifa.out_data !== 4'hF) begin errors++; $display("FAIL rh_restart: %0d cycles data=%h want 5/f", n, ifa.out_data); end
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      en  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 6);
      ld  = ($urandom_range(0, 39) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      model_edge(en, ld, sd, rdy);
      tick();
      checks++;
      if (st_a !== 4'(m_state) || ifa.out_valid !== m_valid || lk_a !== m_lock ||
          (m_valid && ifa.out_data !== m_data)) begin
        errors++;
        $display("FAIL rand_c%0d: state=%h valid=%b data=%h lockup=%b want %h/%b/%h/%b",
                 c, st_a, ifa.out_valid, ifa.out_data, lk_a, 4'(m_state), m_valid, m_data, m_lock);
      end
    end
    ld = 0;
  endtask

  initial begin
    rst_n = 0; en = 0; ld = 0; rdy = 0; sd = 0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_enable_pause();
    test_load();
    test_lockup();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
